// File: rtl/fitness_pkg.sv
// fitness_pkg: shared state encoding and widths for the workout timer controller.
package fitness_pkg;
  localparam int SETTINGS_W = 8;
  localparam int TIME_W = 8;
  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/fitness_timer_ctrl_if.sv
// fitness_timer_ctrl_if: switch/button inputs, calculator link and display outputs of the timer controller.
//   master: drives settings/start/pause and the calculator result calc_time
//   slave : the controller; drives calc_bits, minutes, seconds, busy, paused, done
interface fitness_timer_ctrl_if;
  import fitness_pkg::*;
  logic [SETTINGS_W-1:0] settings;
  logic start;
  logic pause;
  logic [SETTINGS_W-1:0] calc_bits;
  logic [TIME_W-1:0] calc_time;
  logic [TIME_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic busy;
  logic paused;
  logic done;
  modport master (
    output settings, start, pause, calc_time,
    input  calc_bits, minutes, seconds, busy, paused, done
  );
  modport slave (
    input  settings, start, pause, calc_time,
    output calc_bits, minutes, seconds, busy, paused, done
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..CLK_HZ-1 while enabled, one-cycle tick on wrap.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable; the count holds when low
//   clr      : synchronous clear back to 0
//   tick     : high in the cycle the enabled count wraps
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_HZ);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == W'(CLK_HZ - 1);
  always_comb cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fitness_timer_ctrl.sv
// fitness_timer_ctrl: latches user settings for the time calculator and runs a pausable mm:ss countdown.
//   clk, rst : clock, synchronous active-high reset
//   io       : slave side of fitness_timer_ctrl_if (settings/start/pause/calc_time in;
//              calc_bits/minutes/seconds/busy/paused/done out, all registered)
module fitness_timer_ctrl
  import fitness_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input logic clk,
  input logic rst,
  fitness_timer_ctrl_if.slave io
);
  state_t state_q, state_d;
  logic [SETTINGS_W-1:0] calc_bits_q, calc_bits_d;
  logic [TIME_W-1:0] minutes_q, minutes_d;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic busy_q, busy_d, paused_q, paused_d, done_q, done_d;
  logic start_q, pause_q;
  logic start_rise, pause_rise, tick_en, tick, last_sec;
  assign start_rise = io.start & ~start_q;
  assign pause_rise = io.pause & ~pause_q;
  // A cycle that pauses or aborts must not advance the prescaler, so the
  // count resumes exactly where it stopped.
  assign tick_en = state_q == RUN && !start_rise && !pause_rise;
  assign last_sec = minutes_q == '0 && seconds_q == SEC_W'(1);
  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (start_rise),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    calc_bits_d = calc_bits_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          calc_bits_d = io.settings;
          state_d = LOAD;
        end
      end
      LOAD: begin
        minutes_d = io.calc_time;
        seconds_d = '0;
        state_d = io.calc_time == '0 ? DONE : RUN;
      end
      RUN, PAUSE: begin
        if (start_rise) begin
          state_d = IDLE;
          minutes_d = '0;
          seconds_d = '0;
        end else if (pause_rise) begin
          state_d = state_q == RUN ? PAUSE : RUN;
        end else if (tick) begin
          seconds_d = seconds_q == '0 ? SEC_MAX : seconds_q - SEC_W'(1);
          minutes_d = seconds_q == '0 ? minutes_q - TIME_W'(1) : minutes_q;
          state_d = last_sec ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {LOAD, RUN, PAUSE};
    paused_d = state_d == PAUSE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      calc_bits_q <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      busy_q <= 1'b0;
      paused_q <= 1'b0;
      done_q <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      calc_bits_q <= calc_bits_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      busy_q <= busy_d;
      paused_q <= paused_d;
      done_q <= done_d;
      start_q <= io.start;
      pause_q <= io.pause;
    end
  end
  assign io.calc_bits = calc_bits_q;
  assign io.minutes = minutes_q;
  assign io.seconds = seconds_q;
  assign io.busy = busy_q;
  assign io.paused = paused_q;
  assign io.done = done_q;
endmodule
